// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin arbiter driving the select lines of a 4:1 mux.
// A grant is held for at most MAX_HOLD cycles. Every grant is followed by one
// dead (TURN) cycle with gnt = 0, so two requesters never overlap on the mux
// output. All outputs are registered.
module mux_rr_scheduler #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       busy
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    TURN = 2'b10
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [1:0]    last_r;
  logic [1:0]    last_s;
  logic [CW-1:0] hold_cnt_r;
  logic [CW-1:0] hold_cnt_s;
  logic [3:0]    gnt_s;
  logic [1:0]    sel_s;
  logic [2:0]    win_s;

  // Round-robin search: first requester at or after (last+1) mod 4, with
  // wrap-around. Result is {found, index}. Iterating from the farthest
  // offset down lets the nearest requester overwrite the result.
  function automatic logic [2:0] pick_winner(input logic [3:0] req_v,
                                             input logic [1:0] last_v);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int off = 4; off >= 1; off--) begin
      idx = last_v + off[1:0];
      if (req_v[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Index to one-hot grant vector.
  function automatic logic [3:0] to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Next-state, next-grant and counter logic.
  always_comb begin
    state_s    = state_r;
    last_s     = last_r;
    hold_cnt_s = hold_cnt_r;
    gnt_s      = gnt;
    sel_s      = {s1, s0};
    win_s      = pick_winner(req, last_r);
    case (state_r)
      IDLE, TURN: begin
        if (win_s[2]) begin
          state_s    = HOLD;
          gnt_s      = to_onehot(win_s[1:0]);
          sel_s      = win_s[1:0];
          last_s     = win_s[1:0];
          hold_cnt_s = CNT_ONE;
        end else begin
          state_s    = IDLE;
          gnt_s      = 4'b0000;
          hold_cnt_s = CNT_ZERO;
        end
      end
      HOLD: begin
        // last_r is the current owner; other requests are ignored here.
        if (req[last_r] && (hold_cnt_r < MAX_CNT)) begin
          state_s    = HOLD;
          hold_cnt_s = hold_cnt_r + CNT_ONE;
        end else begin
          state_s    = TURN;
          gnt_s      = 4'b0000;
          hold_cnt_s = CNT_ZERO;
        end
      end
      default: begin
        state_s    = IDLE;
        gnt_s      = 4'b0000;
        hold_cnt_s = CNT_ZERO;
      end
    endcase
  end

  // State and output registers; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_r     <= 2'd3;
      hold_cnt_r <= CNT_ZERO;
      gnt        <= 4'b0000;
      s1         <= 1'b0;
      s0         <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_r     <= last_s;
      hold_cnt_r <= hold_cnt_s;
      gnt        <= gnt_s;
      s1         <= sel_s[1];
      s0         <= sel_s[0];
      busy       <= |gnt_s;
    end
  end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler: the stimulus process pushes the
// hand-computed output expected after each clock edge; a monitor pops and
// compares every cycle and also checks the output invariants continuously.
module tb_mux_rr_scheduler;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       busy;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] sel;
  } exp_t;

  exp_t  exp_q[$];
  string tag;
  int    tests;
  int    fails;
  int    run_len;

  mux_rr_scheduler #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .s1   (s1),
    .s0   (s0),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic r, input logic [3:0] rq,
                     input logic [3:0] eg, input logic [1:0] es);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    @(posedge clk);
    e.tag = tag;
    e.gnt = eg;
    e.sel = es;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard compare plus continuous output invariants.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] gidx;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (gnt !== e.gnt || {s1, s0} !== e.sel || busy !== (e.gnt != 4'b0000)) begin
        fails++;
        $display("FAIL %s: got gnt=%b sel=%b busy=%b, want gnt=%b sel=%b busy=%b",
                 e.tag, gnt, {s1, s0}, busy, e.gnt, e.sel, (e.gnt != 4'b0000));
      end
    end
    // one-hot-or-zero
    tests++;
    if ((gnt & (gnt - 4'd1)) !== 4'b0000) begin
      fails++;
      $display("FAIL onehot: got gnt=%b, want zero or one-hot", gnt);
    end
    // busy tracks the grant
    tests++;
    if (busy !== (|gnt)) begin
      fails++;
      $display("FAIL busy: got busy=%b, want %b (gnt=%b)", busy, |gnt, gnt);
    end
    // select matches granted index
    if (busy === 1'b1) begin
      gidx = gnt[1] ? 2'd1 : gnt[2] ? 2'd2 : gnt[3] ? 2'd3 : 2'd0;
      tests++;
      if ({s1, s0} !== gidx) begin
        fails++;
        $display("FAIL selidx: got sel=%b, want %b (gnt=%b)", {s1, s0}, gidx, gnt);
      end
    end
    // grant never held longer than MAX_HOLD consecutive cycles
    if (gnt != 4'b0000) begin
      run_len++;
      tests++;
      if (run_len > MAX_HOLD) begin
        fails++;
        $display("FAIL maxhold: got run=%0d cycles, want <= %0d", run_len, MAX_HOLD);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    tests   = 0;
    fails   = 0;
    run_len = 0;
    rst     = 1'b1;
    req     = 4'b0000;

    // Reset state
    tag = "reset";
    cyc(1'b1, 4'b0000, 4'b0000, 2'b00);
    cyc(1'b1, 4'b1111, 4'b0000, 2'b00);
    tag = "idle";
    cyc(1'b0, 4'b0000, 4'b0000, 2'b00);

    // All requesting: rotation 0,1,2,3,0, four cycles each, one TURN cycle
    tag = "rotate";
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++)
        cyc(1'b0, 4'b1111, 4'b0001 << (r % 4), 2'(r % 4));
      if (r < 4)
        cyc(1'b0, 4'b1111, 4'b0000, 2'(r % 4));
    end
    tag = "rotate_end";
    cyc(1'b0, 4'b0000, 4'b0000, 2'b00);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b00);

    // Short request: early release, select holds in TURN/IDLE
    tag = "short";
    cyc(1'b0, 4'b0100, 4'b0100, 2'b10);
    cyc(1'b0, 4'b0100, 4'b0100, 2'b10);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b10);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b10);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b10);

    // Lone requester: timeout then re-grant after TURN
    tag = "lone";
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++)
        cyc(1'b0, 4'b0001, 4'b0001, 2'b00);
      cyc(1'b0, 4'b0001, 4'b0000, 2'b00);
    end
    cyc(1'b0, 4'b0000, 4'b0000, 2'b00);

    // Owner 1, req[3] rises mid-hold (ignored), then req[1] drops
    tag = "handoff";
    cyc(1'b0, 4'b0010, 4'b0010, 2'b01);
    cyc(1'b0, 4'b1010, 4'b0010, 2'b01);
    cyc(1'b0, 4'b1000, 4'b0000, 2'b01);
    cyc(1'b0, 4'b1000, 4'b1000, 2'b11);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b11);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b11);

    // Timed-out owner 0 loses priority to pending requester 1
    tag = "timeout_rr";
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 4'b0011, 4'b0001, 2'b00);
    cyc(1'b0, 4'b0011, 4'b0000, 2'b00);
    cyc(1'b0, 4'b0011, 4'b0010, 2'b01);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b01);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b01);

    // Reset during requester 2's second HOLD cycle
    tag = "mid_reset";
    cyc(1'b0, 4'b0100, 4'b0100, 2'b10);
    cyc(1'b0, 4'b0100, 4'b0100, 2'b10);
    cyc(1'b1, 4'b0100, 4'b0000, 2'b00);
    tag = "post_reset";
    cyc(1'b0, 4'b0101, 4'b0001, 2'b00);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b00);
    cyc(1'b0, 4'b0000, 4'b0000, 2'b00);

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 20 && exp_q.size() > 0; w++)
      @(posedge clk);
    @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
